// File: rtl/tinker_fetch_unit.sv
// Instruction fetch unit: sequential PC generation feeding a DEPTH-entry
// in-order instruction queue, with downstream redirect and fetch hold.
module tinker_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [63:0]                imem_addr,
    input  logic [31:0]                imem_data,
    input  logic                       fetch_hold,
    input  logic                       redirect_valid,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q    [DEPTH];

    logic          push;
    logic          pop;

    always_comb begin
        pop  = out_valid && out_ready;
        push = !redirect_valid && !fetch_hold && ((count < CW'(DEPTH)) || pop);
    end

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];
    assign occupancy = count;

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= imem_data;
            pc_q[wr_ptr]    <= fetch_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // Flush by collapsing the read pointer onto the write pointer.
            fetch_pc <= redirect_pc;
            rd_ptr   <= wr_ptr;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 64'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
